mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-side stage directly downstream of the multicycle datapath.
- Accepts one read or write request per transaction, based on the datapath's MemRead/MemWrite strobes and its IorD-selected address.
- Sequences the access to a synchronous, word-addressed RAM that has a fixed read latency.
- Returns captured read data plus a one-cycle done pulse that the control unit uses to advance out of its memory states.

Parameters:
- ADDR_W, 32, width of the byte address from the datapath.
- DATA_W, 32, width of data words.
- MEM_ADDR_W, 8, RAM word-address width; RAM depth is 2^MEM_ADDR_W words.
- WAIT_CYCLES, 1, RAM read latency in cycles; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_read  in  1  read request, sampled only in IDLE.
- mem_write  in  1  write request, sampled only in IDLE.
- addr  in  ADDR_W  byte address.
- wdata  in  DATA_W  write data.
- rdata  out  DATA_W  last successfully read word (memory data register).
- done  out  1  one-cycle completion pulse.
- err  out  2  completion status, valid while done=1.
- busy  out  1  high whenever state is not IDLE.
- ram_addr  out  MEM_ADDR_W  RAM word address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_we  out  1  RAM write strobe.
- ram_re  out  1  RAM read strobe.
- ram_rdata  in  DATA_W  RAM read data.

Behaviour:
- Reset: all outputs, including rdata and the wait counter, clear to 0; state goes to IDLE.
- Reset asserted mid-transaction aborts it immediately. ram_we and ram_re drop asynchronously; no done pulse is produced.
- States: IDLE, ACCESS, WAIT, DONE, ERR.
- Error codes: 00 OK, 01 MISALIGNED, 10 RANGE, 11 CONFLICT.
- IDLE, request checks (request sampled in cycle T), evaluated in priority order:
  - mem_read and mem_write both high -> ERR, err=11.
  - addr[1:0] != 0 -> ERR, err=01.
  - addr[ADDR_W-1:MEM_ADDR_W+2] != 0 -> ERR, err=10.
  - Otherwise latch the address, wdata and direction, then go to ACCESS.
- IDLE with no request: stay in IDLE.
- ERR (cycle T+1): done=1 with err set; no RAM strobe is asserted; next state IDLE.
- ACCESS (cycle T+1):
  - ram_addr = latched addr[MEM_ADDR_W+1:2].
  - Write: ram_we=1 and ram_wdata = latched wdata, for exactly this cycle; next state DONE.
  - Read: ram_re=1 for exactly this cycle; load the wait counter with WAIT_CYCLES-1; next state WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, rdata <= ram_rdata on that clock edge; next state DONE.
  - WAIT lasts exactly WAIT_CYCLES cycles.
- DONE: done=1, err=00; next state IDLE.
- Latency from request cycle T to the done pulse:
  - Write: done in T+2.
  - Read: done in T+2+WAIT_CYCLES (T+3 at the default).
  - Error: done in T+1.
- The earliest next request is accepted in the cycle after done. Throughput is one transaction per 3 cycles for writes and per 3+WAIT_CYCLES cycles for reads.
- Requests arriving while busy=1 are ignored, not queued.
- ram_addr and ram_wdata hold their last values outside ACCESS. The strobes are the only qualifiers.
- rdata changes only on successful read capture. It holds across writes, errors and idle periods.
- Address wrap-around: none. Any address beyond the RAM depth is a RANGE error and is never truncated.
- done, ram_we and ram_re are never high for two consecutive cycles.

Decomposition:
- Shared package mem_pkg holds:
  - the state enum (IDLE, ACCESS, WAIT, DONE, ERR);
  - the error-code constants ERR_OK, ERR_MISALIGN, ERR_RANGE, ERR_CONFLICT;
  - the default latency constant.
- One sub-module, mem_wait_counter: a loadable 4-bit down-counter with load, enable and zero outputs, reset asynchronously to 0.
- Everything else lives in mem_access_unit.

Test Plan:
- Write 0xDEADBEEF to addr 0x10, then read 0x10 (WAIT_CYCLES=1):
  - ram_we pulses once with ram_addr=4;
  - the write's done pulse comes 2 cycles after its request;
  - the read's done comes 3 cycles after its request, with rdata=0xDEADBEEF and err=00.
- Read addr 0x13 -> done 1 cycle later with err=01; ram_re/ram_we never assert; rdata is unchanged.
- mem_read=mem_write=1 at addr 0x0 -> done next cycle with err=11 and no RAM strobe. Separately, addr 0x400 with MEM_ADDR_W=8 -> err=10.
- WAIT_CYCLES=3, RAM model with 3-cycle latency, read addr 0x8 holding 0x12345678:
  - done 5 cycles after the request with the correct rdata;
  - a second request held during busy is ignored until IDLE.
- Assert reset during WAIT of a read:
  - busy, done, ram_re and rdata go to 0 immediately, with no done pulse;
  - after release, a new write completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory access stage: controller state encoding,
// completion status codes and the default RAM read latency.
// ---------------------------------------------------------------------------
package mem_pkg;

    // Controller states of mem_access_unit.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        WAIT   = 3'd2,
        DONE   = 3'd3,
        ERR    = 3'd4
    } state_t;

    // Completion status reported on err while done is high.
    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;
    localparam logic [1:0] ERR_CONFLICT = 2'b11;

    // Read latency of the attached RAM when nothing else is configured.
    localparam int DEFAULT_WAIT_CYCLES = 1;

endpackage

// File: rtl/mem_wait_counter.sv
// ---------------------------------------------------------------------------
// mem_wait_counter
// Loadable 4-bit down-counter that times the RAM read latency. It stops at 0
// rather than wrapping, so a stray enable after expiry is harmless.
//
// Ports:
//   clk         system clock
//   reset       asynchronous active-high reset, clears the count
//   load        load load_value (takes priority over enable)
//   enable      decrement by one when the count is non-zero
//   load_value  value to load
//   count       current count
//   zero        high when count is 0
// ---------------------------------------------------------------------------
module mem_wait_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       enable,
    input  logic [3:0] load_value,
    output logic [3:0] count,
    output logic       zero
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    assign zero = (count == 4'd0);

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Memory-side stage behind the multicycle datapath. Takes one read or write
// request at a time, validates it, drives a synchronous word-addressed RAM
// with a fixed read latency, captures read data into the memory data
// register and reports completion with a one-cycle done pulse plus status.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   mem_read, mem_write   request strobes, sampled only while idle
//   addr, wdata           byte address and write data of the request
//   rdata                 last successfully read word
//   done, err             completion pulse and its status code
//   busy                  high whenever a transaction is in progress
//   ram_addr, ram_wdata   RAM word address / write data (hold between uses)
//   ram_we, ram_re        RAM write / read strobes, one cycle per access
//   ram_rdata             RAM read data
// ---------------------------------------------------------------------------
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_ADDR_W  = 8,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES  // legal range 1..15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata,
    output logic                  done,
    output logic [1:0]            err,
    output logic                  busy,
    output logic [MEM_ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    output logic                  ram_we,
    output logic                  ram_re,
    input  logic [DATA_W-1:0]     ram_rdata
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t     state;
    state_t     next_state;
    logic       is_write;
    logic [1:0] err_code;
    logic       req;
    logic       req_bad;
    logic [1:0] req_err;
    logic       cnt_zero;
    logic [3:0] cnt_value;

    assign req = mem_read || mem_write;

    // Request validation, in priority order. Addresses past the RAM depth are
    // rejected, never truncated into range.
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned; an unassigned path infers a latch.
    always_comb begin
        req_bad = 1'b0;
        req_err = ERR_OK;
        if (mem_read && mem_write) begin
            req_bad = 1'b1;
            req_err = ERR_CONFLICT;
        end else if (addr[1:0] != 2'b00) begin
            req_bad = 1'b1;
            req_err = ERR_MISALIGN;
        end else if (addr[ADDR_W-1:MEM_ADDR_W+2] != '0) begin
            req_bad = 1'b1;
            req_err = ERR_RANGE;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req) next_state = req_bad ? ERR : ACCESS;
            ACCESS:  next_state = is_write ? DONE : WAIT;
            WAIT:    if (cnt_zero) next_state = DONE;
            DONE:    next_state = IDLE;
            ERR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Request latch and memory data register. Requests arriving while busy are
    // simply never sampled.
    // NOTE: rdata is a single architectural register, not RAM storage, so it
    // takes the reset like every other flop here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_addr  <= '0;
            ram_wdata <= '0;
            is_write  <= 1'b0;
            err_code  <= ERR_OK;
            rdata     <= '0;
        end else begin
            if (state == IDLE && req) begin
                if (req_bad) begin
                    err_code <= req_err;
                end else begin
                    ram_addr  <= addr[MEM_ADDR_W+1:2];
                    ram_wdata <= wdata;
                    is_write  <= mem_write;
                end
            end
            if (state == WAIT && cnt_zero) begin
                rdata <= ram_rdata;
            end
        end
    end

    // Loaded with WAIT_CYCLES-1 as ACCESS ends, so WAIT spans WAIT_CYCLES
    // cycles and the capture lands on the edge where it reads zero.
    mem_wait_counter u_wait_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (state == ACCESS && !is_write),
        .enable     (state == WAIT),
        .load_value (WAIT_LOAD),
        .count      (cnt_value),
        .zero       (cnt_zero)
    );

    // Strobes decode straight from state, so reset drops them asynchronously
    // and each can only be high for the single ACCESS cycle.
    assign ram_we = (state == ACCESS) && is_write;
    assign ram_re = (state == ACCESS) && !is_write;
    assign busy   = (state != IDLE);
    assign done   = (state == DONE) || (state == ERR);
    assign err    = (state == ERR) ? err_code : ERR_OK;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
// Two instances: u0 with a 1-cycle RAM, u1 with a 3-cycle RAM. Each RAM model
// returns a poison word unless it was strobed exactly its latency ago.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;
    import mem_pkg::*;

    typedef struct {
        int          cyc;
        logic [1:0]  err;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  err;
        int          lat;
        logic [31:0] rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic [1:0]  reset = 2'b11;
    logic [1:0]  mem_read = 2'b00;
    logic [1:0]  mem_write = 2'b00;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic [1:0]  done;
    logic [1:0]  err [2];
    logic [1:0]  busy;
    logic [7:0]  ram_addr [2];
    logic [31:0] ram_wdata [2];
    logic [1:0]  ram_we;
    logic [1:0]  ram_re;
    logic [31:0] ram_rdata [2];

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   we_cnt [2] = '{0, 0};
    int   re_cnt [2] = '{0, 0};
    logic [7:0] we_addr [2];
    logic [1:0] done_prev = 2'b00, we_prev = 2'b00, re_prev = 2'b00;
    exp_t q0 [$];
    exp_t q1 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_access_unit #(.WAIT_CYCLES(1)) u0 (
        .clk(clk), .reset(reset[0]), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
        .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]), .done(done[0]), .err(err[0]),
        .busy(busy[0]), .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]),
        .ram_we(ram_we[0]), .ram_re(ram_re[0]), .ram_rdata(ram_rdata[0])
    );

    mem_access_unit #(.WAIT_CYCLES(3)) u1 (
        .clk(clk), .reset(reset[1]), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
        .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]), .done(done[1]), .err(err[1]),
        .busy(busy[1]), .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]),
        .ram_we(ram_we[1]), .ram_re(ram_re[1]), .ram_rdata(ram_rdata[1])
    );

    // RAM models: 1-cycle and 3-cycle read pipelines.
    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];
    logic [31:0] p0, p1a, p1b, p1c;
    always @(posedge clk) begin
        if (ram_we[0]) mem0[ram_addr[0]] <= ram_wdata[0];
        p0 <= ram_re[0] ? mem0[ram_addr[0]] : 32'hBAD0BAD0;
        if (ram_we[1]) mem1[ram_addr[1]] <= ram_wdata[1];
        p1a <= ram_re[1] ? mem1[ram_addr[1]] : 32'hBAD1BAD1;
        p1b <= p1a;
        p1c <= p1b;
    end
    assign ram_rdata[0] = p0;
    assign ram_rdata[1] = p1c;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: pops an expectation on every done pulse and watches
    // that no pulse output is ever high on two consecutive cycles.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (done[i]) begin
                check($sformatf("done_twice_u%0d", i), {31'b0, done_prev[i]}, 32'd0);
                if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                    check($sformatf("unexpected_done_u%0d", i), {31'b0, done[i]}, 32'd0);
                end else begin
                    if (i == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    check($sformatf("done_cycle_u%0d", i), cyc, e.cyc);
                    check($sformatf("err_u%0d", i), {30'b0, err[i]}, {30'b0, e.err});
                    check($sformatf("rdata_u%0d", i), rdata[i], e.rdata);
                end
            end
            if (ram_we[i]) begin
                check($sformatf("we_twice_u%0d", i), {31'b0, we_prev[i]}, 32'd0);
                we_cnt[i]++;
                we_addr[i] = ram_addr[i];
            end
            if (ram_re[i]) begin
                check($sformatf("re_twice_u%0d", i), {31'b0, re_prev[i]}, 32'd0);
                re_cnt[i]++;
            end
        end
        done_prev = done;
        we_prev   = ram_we;
        re_prev   = ram_re;
    end

    // One-cycle request; lat = 0 means no completion is expected.
    task automatic req(input int i, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input int lat, input logic [1:0] e_err,
                       input logic [31:0] e_rd, output int t);
        exp_t e;
        @(negedge clk);
        mem_read[i] = rd;
        mem_write[i] = wr;
        addr[i] = a;
        wdata[i] = d;
        t = cyc;
        if (lat > 0) begin
            e.cyc = t + lat;
            e.err = e_err;
            e.rdata = e_rd;
            if (i == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(negedge clk);
        mem_read[i] = 1'b0;
        mem_write[i] = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t       vecs [12];
        int         t, we0, re0;
        logic       ok;
        logic [7:0] last_word;
        exp_t       e;

        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, ERR_OK,       2, 32'h0000_0000};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         ERR_OK,       3, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,         ERR_MISALIGN, 1, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b1, 1'b1, 32'h0000_0000, 32'h1111_1111, ERR_CONFLICT, 1, 32'hDEAD_BEEF};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_0400, 32'h0,         ERR_RANGE,    1, 32'hDEAD_BEEF};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_03FC, 32'hCAFE_F00D, ERR_OK,       2, 32'hDEAD_BEEF};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0,         ERR_OK,       3, 32'hCAFE_F00D};
        vecs[7]  = '{1'b1, 1'b1, 32'h0000_0401, 32'h2222_2222, ERR_CONFLICT, 1, 32'hCAFE_F00D};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_0401, 32'h0,         ERR_MISALIGN, 1, 32'hCAFE_F00D};
        vecs[9]  = '{1'b0, 1'b1, 32'h8000_0010, 32'h3333_3333, ERR_RANGE,    1, 32'hCAFE_F00D};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         ERR_OK,       3, 32'hDEAD_BEEF};
        vecs[11] = '{1'b0, 1'b1, 32'h0000_0002, 32'h4444_4444, ERR_MISALIGN, 1, 32'hDEAD_BEEF};

        for (int i = 0; i < 2; i++) begin
            addr[i] = '0;
            wdata[i] = '0;
        end
        repeat (2) @(negedge clk);
        reset = 2'b00;
        @(negedge clk);

        // Reset state of both instances.
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset_rdata_u%0d", i), rdata[i], 32'd0);
            check($sformatf("reset_flags_u%0d", i),
                  {28'b0, done[i], busy[i], ram_we[i], ram_re[i]}, 32'd0);
            check($sformatf("reset_err_u%0d", i), {30'b0, err[i]}, 32'd0);
            check($sformatf("reset_ram_addr_u%0d", i), {24'b0, ram_addr[i]}, 32'd0);
            check($sformatf("reset_ram_wdata_u%0d", i), ram_wdata[i], 32'd0);
        end

        // Table-driven transactions on the 1-cycle instance.
        last_word = 8'd0;
        for (int v = 0; v < 12; v++) begin
            we0 = we_cnt[0];
            re0 = re_cnt[0];
            req(0, vecs[v].rd, vecs[v].wr, vecs[v].a, vecs[v].d, vecs[v].lat,
                vecs[v].err, vecs[v].rdata, t);
            wait_until(t + vecs[v].lat + 1);
            ok = (vecs[v].err == ERR_OK);
            check($sformatf("we_pulses_v%0d", v), we_cnt[0] - we0, {31'b0, ok && vecs[v].wr});
            check($sformatf("re_pulses_v%0d", v), re_cnt[0] - re0, {31'b0, ok && vecs[v].rd});
            if (ok) last_word = vecs[v].a[9:2];
            check($sformatf("ram_addr_hold_v%0d", v), {24'b0, ram_addr[0]}, {24'b0, last_word});
            if (ok && vecs[v].wr) begin
                check($sformatf("we_addr_v%0d", v), {24'b0, we_addr[0]}, {24'b0, last_word});
                check($sformatf("ram_wdata_v%0d", v), ram_wdata[0], vecs[v].d);
            end
            check($sformatf("idle_after_v%0d", v), {31'b0, busy[0]}, 32'd0);
        end

        // 3-cycle instance: fill two words.
        req(1, 1'b0, 1'b1, 32'h8, 32'h1234_5678, 2, ERR_OK, 32'h0, t);
        wait_until(t + 3);
        req(1, 1'b0, 1'b1, 32'hC, 32'hA5A5_5A5A, 2, ERR_OK, 32'h0, t);
        wait_until(t + 3);

        // Read 0x8 while a second read request is held throughout the busy
        // period; it is only taken once the unit is back in IDLE.
        re0 = re_cnt[1];
        @(negedge clk);
        mem_read[1] = 1'b1;
        addr[1] = 32'h8;
        t = cyc;
        e.cyc = t + 5; e.err = ERR_OK; e.rdata = 32'h1234_5678;
        q1.push_back(e);
        e.cyc = t + 11; e.err = ERR_OK; e.rdata = 32'hA5A5_5A5A;
        q1.push_back(e);
        do begin
            @(negedge clk);
            if (cyc == t + 1) addr[1] = 32'hC;
            check($sformatf("busy_held_c%0d", cyc - t), {31'b0, busy[1]},
                  {31'b0, cyc != t + 6});
        end while (cyc < t + 7);
        mem_read[1] = 1'b0;
        wait_until(t + 12);
        check("held_read_pulses", re_cnt[1] - re0, 32'd2);

        // Reset during WAIT aborts the read with no done pulse.
        req(1, 1'b1, 1'b0, 32'h8, 32'h0, 0, ERR_OK, 32'h0, t);
        wait_until(t + 3);
        check("in_wait_busy", {31'b0, busy[1]}, 32'd1);
        reset[1] = 1'b1;
        #1;
        check("abort_flags", {28'b0, busy[1], done[1], ram_re[1], ram_we[1]}, 32'd0);
        check("abort_rdata", rdata[1], 32'd0);
        check("abort_err", {30'b0, err[1]}, 32'd0);
        repeat (2) @(negedge clk);
        reset[1] = 1'b0;
        req(1, 1'b0, 1'b1, 32'h20, 32'h0BAD_F00D, 2, ERR_OK, 32'h0, t);
        wait_until(t + 3);
        check("post_reset_we_addr", {24'b0, we_addr[1]}, 32'h8);
        req(1, 1'b1, 1'b0, 32'h20, 32'h0, 5, ERR_OK, 32'h0BAD_F00D, t);
        wait_until(t + 6);

        repeat (3) @(negedge clk);
        check("pending_u0", q0.size(), 32'd0);
        check("pending_u1", q1.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
